// File: rtl/sram_1rw_req_ctrl.sv
// sram_1rw_req_ctrl: request front-end for a single-port 1RW masked SRAM macro.
// Zero-fills the array after reset (INIT), then arbitrates a write channel and a read
// channel onto the one RW port with a bounded-starvation rule for reads. Read data is
// captured into a credit-controlled response FIFO, so a stalled consumer never loses data.
// Optional build macro: SRAM_CTRL_PERF_CNT_EN adds write/read/conflict event counters.
module sram_1rw_req_ctrl #(
  parameter int unsigned ADDR_W     = 2,
  parameter int unsigned DATA_W     = 456,
  parameter int unsigned MASK_W     = 4,
  parameter int unsigned STARVE_MAX = 4,
  parameter int unsigned RESP_DEPTH = 2
) (
  input  logic              clock,
  input  logic              reset,
  output logic              init_done,
  input  logic              w_valid,
  output logic              w_ready,
  input  logic [ADDR_W-1:0] w_addr,
  input  logic [MASK_W-1:0] w_mask,
  input  logic [DATA_W-1:0] w_data,
  input  logic              r_valid,
  output logic              r_ready,
  input  logic [ADDR_W-1:0] r_addr,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [DATA_W-1:0] resp_data,
  output logic              sram_en,
  output logic              sram_wmode,
  output logic [ADDR_W-1:0] sram_addr,
  output logic [MASK_W-1:0] sram_wmask,
  output logic [DATA_W-1:0] sram_wdata,
`ifdef SRAM_CTRL_PERF_CNT_EN
  output logic [31:0]       perf_wr_cnt,
  output logic [31:0]       perf_rd_cnt,
  output logic [31:0]       perf_conflict_cnt,
`endif
  input  logic [DATA_W-1:0] sram_rdata
);

  localparam int unsigned StarveW = $clog2(STARVE_MAX + 1);
  localparam int unsigned CntW    = $clog2(RESP_DEPTH + 1);
  localparam int unsigned PtrW    = (RESP_DEPTH > 1) ? $clog2(RESP_DEPTH) : 1;

  localparam logic [ADDR_W-1:0]  LastAddr  = {ADDR_W{1'b1}};
  localparam logic [StarveW-1:0] StarveMax = StarveW'(STARVE_MAX);
  localparam logic [CntW:0]      Depth     = (CntW + 1)'(RESP_DEPTH);
  localparam logic [PtrW-1:0]    LastPtr   = PtrW'(RESP_DEPTH - 1);

  typedef enum logic [0:0] {StInit, StRun} state_e;

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   init_addr_q, init_addr_d;
  logic [StarveW-1:0]  starve_q, starve_d;
  logic                inflight_q;
  logic [CntW-1:0]     count_q;
  logic [PtrW-1:0]     wptr_q, rptr_q;
  logic [DATA_W-1:0]   fifo_mem [RESP_DEPTH];

  logic                wr_grant, rd_grant;
  logic                rd_ok;
  logic [CntW:0]       credit_used;
  logic                fifo_push, fifo_pop;

  // A read may issue only if its response is guaranteed a FIFO slot (entries + in-flight).
  assign credit_used = {1'b0, count_q} + {{CntW{1'b0}}, inflight_q};
  assign rd_ok       = credit_used < Depth;

  assign init_done  = (state_q == StRun);
  assign resp_valid = (count_q != '0);
  assign resp_data  = fifo_mem[rptr_q];
  assign fifo_push  = inflight_q;
  assign fifo_pop   = resp_valid && resp_ready;
  assign w_ready    = wr_grant;
  assign r_ready    = rd_grant;

  // Arbitration, SRAM port drive, INIT sequencing and starvation counter next-state.
  always_comb begin
    state_d     = state_q;
    init_addr_d = init_addr_q;
    starve_d    = starve_q;
    wr_grant    = 1'b0;
    rd_grant    = 1'b0;
    sram_en     = 1'b0;
    sram_wmode  = 1'b0;
    sram_addr   = w_addr;
    sram_wmask  = w_mask;
    sram_wdata  = w_data;

    unique case (state_q)
      StInit: begin
        sram_en    = 1'b1;
        sram_wmode = 1'b1;
        sram_addr  = init_addr_q;
        sram_wmask = '1;
        sram_wdata = '0;
        if (init_addr_q == LastAddr) begin
          state_d = StRun;
        end else begin
          init_addr_d = init_addr_q + 1'b1;
        end
      end
      StRun: begin
        if (w_valid && r_valid) begin
          if (rd_ok && (starve_q == StarveMax)) begin
            rd_grant = 1'b1;
          end else begin
            wr_grant = 1'b1;
          end
        end else if (w_valid) begin
          wr_grant = 1'b1;
        end else if (r_valid) begin
          rd_grant = rd_ok;
        end

        // Only count write wins that actually delayed a read that could have issued.
        if (rd_grant || !r_valid) begin
          starve_d = '0;
        end else if (wr_grant && rd_ok && (starve_q != StarveMax)) begin
          starve_d = starve_q + 1'b1;
        end

        if (rd_grant) begin
          sram_en   = 1'b1;
          sram_addr = r_addr;
        end else if (wr_grant) begin
          sram_en    = 1'b1;
          sram_wmode = 1'b1;
        end
      end
      default: state_d = StInit;
    endcase

    // Nothing is issued or accepted while reset is asserted.
    if (reset) begin
      wr_grant = 1'b0;
      rd_grant = 1'b0;
      sram_en  = 1'b0;
    end
  end

  // Control state: FSM, init address, starvation counter, in-flight flag, FIFO pointers.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= StInit;
      init_addr_q <= '0;
      starve_q    <= '0;
      inflight_q  <= 1'b0;
      count_q     <= '0;
      wptr_q      <= '0;
      rptr_q      <= '0;
    end else begin
      state_q     <= state_d;
      init_addr_q <= init_addr_d;
      starve_q    <= starve_d;
      inflight_q  <= rd_grant;
      if (fifo_push) begin
        wptr_q <= (wptr_q == LastPtr) ? '0 : wptr_q + 1'b1;
      end
      if (fifo_pop) begin
        rptr_q <= (rptr_q == LastPtr) ? '0 : rptr_q + 1'b1;
      end
      unique case ({fifo_push, fifo_pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  // Response storage; data is meaningless until counted, so it needs no reset.
  always_ff @(posedge clock) begin
    if (!reset && fifo_push) begin
      fifo_mem[wptr_q] <= sram_rdata;
    end
  end

`ifdef SRAM_CTRL_PERF_CNT_EN
  // Event counters; wrap naturally at 2**32.
  always_ff @(posedge clock) begin
    if (reset) begin
      perf_wr_cnt       <= '0;
      perf_rd_cnt       <= '0;
      perf_conflict_cnt <= '0;
    end else begin
      if (wr_grant) begin
        perf_wr_cnt <= perf_wr_cnt + 32'd1;
      end
      if (rd_grant) begin
        perf_rd_cnt <= perf_rd_cnt + 32'd1;
      end
      if ((state_q == StRun) && w_valid && r_valid) begin
        perf_conflict_cnt <= perf_conflict_cnt + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_sram_1rw_req_ctrl.sv
// tb_sram_1rw_req_ctrl: directed bench for sram_1rw_req_ctrl with a behavioural 1RW
// masked macro (registered read, 1-cycle latency). Inputs change 1 time unit after the
// rising edge; outputs are sampled 1 unit later, well before the next edge.
module tb_sram_1rw_req_ctrl;

  localparam int unsigned ADDR_W     = 2;
  localparam int unsigned DATA_W     = 456;
  localparam int unsigned MASK_W     = 4;
  localparam int unsigned STARVE_MAX = 4;
  localparam int unsigned RESP_DEPTH = 2;
  localparam int unsigned LANE_W     = DATA_W / MASK_W;
  localparam int unsigned ENTRIES    = 1 << ADDR_W;

  logic              clock = 1'b0;
  logic              reset;
  logic              init_done;
  logic              w_valid, w_ready;
  logic [ADDR_W-1:0] w_addr;
  logic [MASK_W-1:0] w_mask;
  logic [DATA_W-1:0] w_data;
  logic              r_valid, r_ready;
  logic [ADDR_W-1:0] r_addr;
  logic              resp_valid, resp_ready;
  logic [DATA_W-1:0] resp_data;
  logic              sram_en, sram_wmode;
  logic [ADDR_W-1:0] sram_addr;
  logic [MASK_W-1:0] sram_wmask;
  logic [DATA_W-1:0] sram_wdata;
  logic [DATA_W-1:0] sram_rdata;
`ifdef SRAM_CTRL_PERF_CNT_EN
  logic [31:0]       perf_wr_cnt, perf_rd_cnt, perf_conflict_cnt;
`endif

  logic [DATA_W-1:0] sram_mem [ENTRIES];
  logic              tb_scramble;
  logic [DATA_W-1:0] d0, d1;

  int checks = 0;
  int passed = 0;

  always #5 clock = ~clock;

  sram_1rw_req_ctrl #(
    .ADDR_W     (ADDR_W),
    .DATA_W     (DATA_W),
    .MASK_W     (MASK_W),
    .STARVE_MAX (STARVE_MAX),
    .RESP_DEPTH (RESP_DEPTH)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .init_done  (init_done),
    .w_valid    (w_valid),
    .w_ready    (w_ready),
    .w_addr     (w_addr),
    .w_mask     (w_mask),
    .w_data     (w_data),
    .r_valid    (r_valid),
    .r_ready    (r_ready),
    .r_addr     (r_addr),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_data  (resp_data),
    .sram_en    (sram_en),
    .sram_wmode (sram_wmode),
    .sram_addr  (sram_addr),
    .sram_wmask (sram_wmask),
    .sram_wdata (sram_wdata),
`ifdef SRAM_CTRL_PERF_CNT_EN
    .perf_wr_cnt       (perf_wr_cnt),
    .perf_rd_cnt       (perf_rd_cnt),
    .perf_conflict_cnt (perf_conflict_cnt),
`endif
    .sram_rdata (sram_rdata)
  );

  // Behavioural macro; scramble fills the array with ones so zero-fill is observable.
  always @(posedge clock) begin
    if (tb_scramble) begin
      for (int i = 0; i < ENTRIES; i++) sram_mem[i] <= '1;
    end else if (sram_en) begin
      if (sram_wmode) begin
        for (int l = 0; l < MASK_W; l++) begin
          if (sram_wmask[l]) sram_mem[sram_addr][l*LANE_W +: LANE_W] <= sram_wdata[l*LANE_W +: LANE_W];
        end
      end else begin
        sram_rdata <= sram_mem[sram_addr];
      end
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic test_reset();
    w_valid = 1'b1;
    r_valid = 1'b1;
    reset   = 1'b1;
    tb_scramble = 1'b1;
    tick();
    tb_scramble = 1'b0;
    tick();
    settle();
    checks++; if (init_done !== 1'b0) $display("FAIL reset_init_done: got %b want 0", init_done); else passed++;
    checks++; if (w_ready !== 1'b0) $display("FAIL reset_w_ready: got %b want 0", w_ready); else passed++;
    checks++; if (r_ready !== 1'b0) $display("FAIL reset_r_ready: got %b want 0", r_ready); else passed++;
    checks++; if (resp_valid !== 1'b0) $display("FAIL reset_resp_valid: got %b want 0", resp_valid); else passed++;
    checks++; if (sram_en !== 1'b0) $display("FAIL reset_sram_en: got %b want 0", sram_en); else passed++;
  endtask

  // Zero-fill takes exactly 4 cycles, then every address reads back as zero.
  task automatic test_init();
    logic [7:0] exp_ctl;
    int issued, got, first_grant;
    reset      = 1'b0;
    w_valid    = 1'b0;
    r_valid    = 1'b1;
    r_addr     = '0;
    resp_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      settle();
      exp_ctl = {1'b1, 1'b1, 2'(k), 4'hf};
      checks++;
      if ({sram_en, sram_wmode, sram_addr, sram_wmask} !== exp_ctl)
        $display("FAIL init_ctl[%0d]: got %h want %h", k, {sram_en, sram_wmode, sram_addr, sram_wmask}, exp_ctl);
      else passed++;
      checks++; if (sram_wdata !== '0) $display("FAIL init_wdata[%0d]: got %h want 0", k, sram_wdata); else passed++;
      checks++; if (r_ready !== 1'b0) $display("FAIL init_r_ready[%0d]: got %b want 0", k, r_ready); else passed++;
      checks++; if (init_done !== 1'b0) $display("FAIL init_done_early[%0d]: got %b want 0", k, init_done); else passed++;
      tick();
    end
    settle();
    checks++; if (init_done !== 1'b1) $display("FAIL init_done_rise: got %b want 1", init_done); else passed++;
    issued = 0;
    got = 0;
    first_grant = -1;
    for (int c = 0; c < 20 && got < 4; c++) begin
      settle();
      if (r_valid && r_ready) begin
        if (issued == 0) first_grant = c;
        checks++;
        if ({sram_en, sram_wmode, sram_addr} !== {1'b1, 1'b0, 2'(issued)})
          $display("FAIL init_rd_issue[%0d]: got %b want %b", issued, {sram_en, sram_wmode, sram_addr}, {1'b1, 1'b0, 2'(issued)});
        else passed++;
        issued++;
      end
      if (resp_valid) begin
        if (got == 0) begin
          checks++; if (c - first_grant != 2) $display("FAIL rd_latency: got %0d want 2", c - first_grant); else passed++;
        end
        checks++; if (resp_data !== '0) $display("FAIL zero_fill[%0d]: got %h want 0", got, resp_data); else passed++;
        got++;
      end
      tick();
      r_valid = (issued < 4);
      r_addr  = ADDR_W'(issued);
    end
    checks++; if (got != 4) $display("FAIL init_reads_done: got %0d want 4", got); else passed++;
    r_valid = 1'b0;
  endtask

  // Lane-masked writes, and a read right after a write sees the new data.
  task automatic test_masked_write();
    logic [DATA_W-1:0] exp1, exp2;
    exp1 = '0;
    exp1[0*LANE_W +: LANE_W] = '1;
    exp1[2*LANE_W +: LANE_W] = '1;
    exp2 = exp1;
    exp2[3*LANE_W +: LANE_W] = d0[3*LANE_W +: LANE_W];
    resp_ready = 1'b1;
    w_valid = 1'b1; w_addr = 2'd2; w_mask = 4'b0101; w_data = '1;
    settle();
    checks++; if (w_ready !== 1'b1) $display("FAIL mw_w_ready: got %b want 1", w_ready); else passed++;
    checks++;
    if ({sram_en, sram_wmode, sram_addr, sram_wmask} !== 8'b1_1_10_0101)
      $display("FAIL mw_ctl: got %b want 11100101", {sram_en, sram_wmode, sram_addr, sram_wmask});
    else passed++;
    tick();
    w_valid = 1'b0; r_valid = 1'b1; r_addr = 2'd2;
    settle();
    checks++;
    if ({r_ready, sram_en, sram_wmode, sram_addr} !== 5'b1_1_0_10)
      $display("FAIL mw_rd_issue: got %b want 11010", {r_ready, sram_en, sram_wmode, sram_addr});
    else passed++;
    tick();
    r_valid = 1'b0;
    settle();
    checks++; if (resp_valid !== 1'b0) $display("FAIL mw_early_resp: got %b want 0", resp_valid); else passed++;
    tick();
    settle();
    checks++; if (resp_valid !== 1'b1) $display("FAIL mw_resp_valid: got %b want 1", resp_valid); else passed++;
    checks++; if (resp_data !== exp1) $display("FAIL mw_data1: got %h want %h", resp_data, exp1); else passed++;
    tick();
    settle();
    checks++; if (resp_valid !== 1'b0) $display("FAIL mw_no_dup: got %b want 0", resp_valid); else passed++;
    w_valid = 1'b1; w_addr = 2'd2; w_mask = 4'b1000; w_data = d0;
    settle();
    checks++; if (w_ready !== 1'b1) $display("FAIL mw2_w_ready: got %b want 1", w_ready); else passed++;
    tick();
    w_valid = 1'b0; r_valid = 1'b1; r_addr = 2'd2;
    settle();
    checks++; if (r_ready !== 1'b1) $display("FAIL mw2_r_ready: got %b want 1", r_ready); else passed++;
    tick();
    r_valid = 1'b0;
    tick();
    settle();
    checks++; if (resp_data !== exp2 || resp_valid !== 1'b1) $display("FAIL mw_data2: got %b/%h want 1/%h", resp_valid, resp_data, exp2); else passed++;
    tick();
  endtask

  // Both channels saturated: 4 writes then 1 read, repeating.
  task automatic test_starve();
    int reads;
    reads = 0;
    resp_ready = 1'b1;
    w_valid = 1'b1; w_addr = 2'd1; w_mask = 4'hf; w_data = d1;
    r_valid = 1'b1; r_addr = 2'd0;
    for (int k = 0; k < 15; k++) begin
      settle();
      checks++;
      if (r_ready !== (k % 5 == 4)) $display("FAIL starve_r_ready[%0d]: got %b want %b", k, r_ready, (k % 5 == 4)); else passed++;
      checks++;
      if (w_ready !== (k % 5 != 4)) $display("FAIL starve_w_ready[%0d]: got %b want %b", k, w_ready, (k % 5 != 4)); else passed++;
      if (r_ready) reads++;
      tick();
    end
    checks++; if (reads != 3) $display("FAIL starve_reads: got %0d want 3", reads); else passed++;
    w_valid = 1'b0; r_valid = 1'b0;
    for (int k = 0; k < 4; k++) tick();
  endtask

  // Consumer stalled: exactly RESP_DEPTH reads accepted, then drained in order.
  task automatic test_backpressure();
    int accepted;
    w_valid = 1'b1; w_addr = 2'd0; w_mask = 4'hf; w_data = d0;
    tick();
    w_addr = 2'd1; w_data = d1;
    tick();
    w_valid = 1'b0;
    resp_ready = 1'b0;
    r_valid = 1'b1; r_addr = 2'd0;
    accepted = 0;
    for (int k = 0; k < 6; k++) begin
      settle();
      checks++; if (r_ready !== (k < 2)) $display("FAIL bp_r_ready[%0d]: got %b want %b", k, r_ready, (k < 2)); else passed++;
      if (r_valid && r_ready) accepted++;
      tick();
      r_addr = ADDR_W'(accepted);
    end
    r_valid = 1'b0;
    settle();
    checks++; if (resp_valid !== 1'b1 || resp_data !== d0) $display("FAIL bp_head_stalled: got %b/%h want 1/%h", resp_valid, resp_data, d0); else passed++;
    resp_ready = 1'b1;
    tick();
    settle();
    checks++; if (resp_valid !== 1'b1 || resp_data !== d1) $display("FAIL bp_second: got %b/%h want 1/%h", resp_valid, resp_data, d1); else passed++;
    tick();
    settle();
    checks++; if (resp_valid !== 1'b0) $display("FAIL bp_drained: got %b want 0", resp_valid); else passed++;
  endtask

  // Reset mid-INIT restarts at 0; reset with a read in flight drops its data.
  task automatic test_reset_mid();
    w_valid = 1'b0; r_valid = 1'b0; resp_ready = 1'b0;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    settle();
    checks++; if (sram_addr !== 2'd0 || sram_en !== 1'b1) $display("FAIL rm_init0: got %b/%0d want 1/0", sram_en, sram_addr); else passed++;
    tick();
    settle();
    checks++; if (sram_addr !== 2'd1) $display("FAIL rm_init1: got %0d want 1", sram_addr); else passed++;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    settle();
    checks++; if (sram_addr !== 2'd0 || init_done !== 1'b0) $display("FAIL rm_restart: got %0d/%b want 0/0", sram_addr, init_done); else passed++;
    for (int k = 1; k < 4; k++) begin
      tick();
      settle();
      checks++; if (sram_addr !== 2'(k)) $display("FAIL rm_addr[%0d]: got %0d want %0d", k, sram_addr, k); else passed++;
    end
    tick();
    settle();
    checks++; if (init_done !== 1'b1) $display("FAIL rm_init_done: got %b want 1", init_done); else passed++;
    w_valid = 1'b1; w_addr = 2'd0; w_mask = 4'hf; w_data = d0;
    tick();
    w_valid = 1'b0; r_valid = 1'b1; r_addr = 2'd0;
    settle();
    checks++; if (r_ready !== 1'b1) $display("FAIL rm_rd_grant: got %b want 1", r_ready); else passed++;
    tick();
    r_valid = 1'b0;
    reset = 1'b1;
    tick();
    settle();
    checks++; if (resp_valid !== 1'b0) $display("FAIL rm_resp_after_reset: got %b want 0", resp_valid); else passed++;
    reset = 1'b0;
    for (int k = 0; k < 5; k++) begin
      settle();
      checks++; if (resp_valid !== 1'b0) $display("FAIL rm_dropped[%0d]: got %b want 0", k, resp_valid); else passed++;
      tick();
    end
    resp_ready = 1'b1; r_valid = 1'b1; r_addr = 2'd0;
    settle();
    checks++; if (r_ready !== 1'b1) $display("FAIL rm_reread_grant: got %b want 1", r_ready); else passed++;
    tick();
    r_valid = 1'b0;
    tick();
    settle();
    checks++; if (resp_valid !== 1'b1 || resp_data !== '0) $display("FAIL rm_rezeroed: got %b/%h want 1/0", resp_valid, resp_data); else passed++;
    tick();
  endtask

`ifdef SRAM_CTRL_PERF_CNT_EN
  task automatic test_perf();
    w_valid = 1'b0; r_valid = 1'b0; resp_ready = 1'b1;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    for (int k = 0; k < 4; k++) tick();
    w_valid = 1'b1; w_addr = 2'd3; w_mask = 4'hf; w_data = d1;
    r_valid = 1'b1; r_addr = 2'd3;
    for (int k = 0; k < 10; k++) tick();
    w_valid = 1'b0; r_valid = 1'b0;
    settle();
    checks++; if (perf_wr_cnt !== 32'd8) $display("FAIL perf_wr: got %0d want 8", perf_wr_cnt); else passed++;
    checks++; if (perf_rd_cnt !== 32'd2) $display("FAIL perf_rd: got %0d want 2", perf_rd_cnt); else passed++;
    checks++; if (perf_conflict_cnt !== 32'd10) $display("FAIL perf_conflict: got %0d want 10", perf_conflict_cnt); else passed++;
  endtask
`endif

  initial begin
    reset = 1'b1; tb_scramble = 1'b1;
    w_valid = 1'b0; w_addr = '0; w_mask = '0; w_data = '0;
    r_valid = 1'b0; r_addr = '0; resp_ready = 1'b0;
    d0 = {57{8'ha5}};
    d1 = {57{8'h3c}};
    test_reset();
    test_init();
    test_masked_write();
    test_starve();
    test_backpressure();
    test_reset_mid();
`ifdef SRAM_CTRL_PERF_CNT_EN
    test_perf();
`endif
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "timeout");
  end

endmodule
